// File: rtl/tank_gfx_pkg.sv
// Shared geometry, colour and slot types for the tank sprite pipeline.
package tank_gfx_pkg;

    localparam int unsigned SPRITE_W  = 32;
    localparam int unsigned SPRITE_H  = 32;
    localparam int unsigned SPRITE_XB = $clog2(SPRITE_W);
    localparam int unsigned SPRITE_YB = $clog2(SPRITE_H);
    localparam int unsigned ROM_AW    = 1 + SPRITE_XB + SPRITE_YB;
    localparam int unsigned COORD_W   = 10;
    localparam int unsigned DIFF_W    = 11;
    localparam int unsigned IDX_W     = 4;

    localparam logic [IDX_W-1:0] TRANSPARENT_IDX = 4'h0;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    typedef enum logic {
        FETCH0 = 1'b0,
        FETCH1 = 1'b1
    } slot_e;

    // ROM address layout: {sprite select, row, column}
    function automatic logic [ROM_AW-1:0] sprite_addr(
        input logic                 sel,
        input logic [SPRITE_XB-1:0] dx,
        input logic [SPRITE_YB-1:0] dy
    );
        return {sel, dy, dx};
    endfunction

endpackage

// File: rtl/tank_sprite_scheduler_if.sv
// Shared sprite ROM and palette bus; the scheduler is the master.
interface tank_sprite_scheduler_if
    import tank_gfx_pkg::*;
#(
    parameter int unsigned ADDR_W = ROM_AW
);

    logic [ADDR_W-1:0] rom_addr;
    logic [IDX_W-1:0]  rom_data;
    logic [IDX_W-1:0]  pal_index;
    logic [3:0]        pal_red;
    logic [3:0]        pal_green;
    logic [3:0]        pal_blue;

    modport master (
        output rom_addr,
        output pal_index,
        input  rom_data,
        input  pal_red,
        input  pal_green,
        input  pal_blue
    );

    modport slave (
        input  rom_addr,
        input  pal_index,
        output rom_data,
        output pal_red,
        output pal_green,
        output pal_blue
    );

endinterface

// File: rtl/sprite_hit.sv
// Bounding-box hit test and ROM address for one sprite at one pixel.
module sprite_hit
    import tank_gfx_pkg::*;
#(
    parameter int unsigned BOX_W  = SPRITE_W,
    parameter int unsigned BOX_H  = SPRITE_H,
    parameter int unsigned ADDR_W = ROM_AW
) (
    input  logic               i_sel,
    input  logic               i_en,
    input  logic [COORD_W-1:0] i_draw_x,
    input  logic [COORD_W-1:0] i_draw_y,
    input  logic [COORD_W-1:0] i_pos_x,
    input  logic [COORD_W-1:0] i_pos_y,
    output logic               o_hit_c,
    output logic [ADDR_W-1:0]  o_addr_c
);

    localparam int unsigned XB = $clog2(BOX_W);
    localparam int unsigned YB = $clog2(BOX_H);

    logic [DIFF_W-1:0] w_dx;
    logic [DIFF_W-1:0] w_dy;

    // Offsets are taken one bit wider so a sprite hanging off the edge clips instead of wrapping
    assign w_dx = DIFF_W'(i_draw_x) - DIFF_W'(i_pos_x);
    assign w_dy = DIFF_W'(i_draw_y) - DIFF_W'(i_pos_y);

    assign o_hit_c = i_en
                  && (i_draw_x >= i_pos_x) && (w_dx < DIFF_W'(BOX_W))
                  && (i_draw_y >= i_pos_y) && (w_dy < DIFF_W'(BOX_H));

    // A miss parks the slot on address 0
    assign o_addr_c = o_hit_c ? ADDR_W'(sprite_addr(i_sel, w_dx[XB-1:0], w_dy[YB-1:0]))
                              : '0;

endmodule

// File: rtl/tank_sprite_scheduler.sv
// Two-tank sprite scheduler: shares one ROM and one palette across two fetch slots per pixel.
module tank_sprite_scheduler #(
    parameter int unsigned SPRITE_W        = tank_gfx_pkg::SPRITE_W,
    parameter int unsigned SPRITE_H        = tank_gfx_pkg::SPRITE_H,
    parameter int unsigned ROM_AW          = tank_gfx_pkg::ROM_AW,
    parameter logic [3:0]  TRANSPARENT_IDX = tank_gfx_pkg::TRANSPARENT_IDX
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   pix_ce,
    input  logic [9:0]             DrawX,
    input  logic [9:0]             DrawY,
    input  logic                   vde,
    input  logic [3:0]             bg_red,
    input  logic [3:0]             bg_green,
    input  logic [3:0]             bg_blue,
    input  logic [9:0]             tank0_x,
    input  logic [9:0]             tank0_y,
    input  logic [9:0]             tank1_x,
    input  logic [9:0]             tank1_y,
    input  logic                   tank0_en,
    input  logic                   tank1_en,
    tank_sprite_scheduler_if.master mem,
    output logic [3:0]             Red,
    output logic [3:0]             Green,
    output logic [3:0]             Blue,
    output logic                   pix_valid
);

    import tank_gfx_pkg::rgb12_t;
    import tank_gfx_pkg::slot_e;
    import tank_gfx_pkg::FETCH0;
    import tank_gfx_pkg::FETCH1;

    logic              w_hit0;
    logic              w_hit1;
    logic [ROM_AW-1:0] w_addr0;
    logic [ROM_AW-1:0] w_addr1;

    // Stage A: sampled pixel, tank-0 slot on the ROM
    slot_e             r_slot;
    logic              r_a_vld;
    logic              r_a_hit0;
    logic              r_a_hit1;
    logic [ROM_AW-1:0] r_a_addr1;
    logic              r_a_vde;
    rgb12_t            r_a_bg;
    logic [ROM_AW-1:0] r_rom_addr;

    // Stage B: idx0 returning, tank-1 slot on the ROM
    logic              r_b_vld;
    logic              r_b_hit0;
    logic              r_b_hit1;
    logic              r_b_vde;
    rgb12_t            r_b_bg;

    // Stage C: idx1 returning, resolve and palette lookup
    logic              r_c_vld;
    logic              r_c_hit0;
    logic              r_c_hit1;
    logic              r_c_vde;
    rgb12_t            r_c_bg;
    logic [3:0]        r_idx0;

    logic              w_pick0;
    logic              w_pick1;
    logic [3:0]        w_pal_index;

    rgb12_t            r_rgb;
    logic              r_pix_valid;

    sprite_hit #(
        .BOX_W  (SPRITE_W),
        .BOX_H  (SPRITE_H),
        .ADDR_W (ROM_AW)
    ) u_hit0 (
        .i_sel    (1'b0),
        .i_en     (tank0_en),
        .i_draw_x (DrawX),
        .i_draw_y (DrawY),
        .i_pos_x  (tank0_x),
        .i_pos_y  (tank0_y),
        .o_hit_c  (w_hit0),
        .o_addr_c (w_addr0)
    );

    sprite_hit #(
        .BOX_W  (SPRITE_W),
        .BOX_H  (SPRITE_H),
        .ADDR_W (ROM_AW)
    ) u_hit1 (
        .i_sel    (1'b1),
        .i_en     (tank1_en),
        .i_draw_x (DrawX),
        .i_draw_y (DrawY),
        .i_pos_x  (tank1_x),
        .i_pos_y  (tank1_y),
        .o_hit_c  (w_hit1),
        .o_addr_c (w_addr1)
    );

    // Sample stage and slot FSM; a pix_ce always restarts at FETCH0, dropping any half-fetched pixel
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_slot     <= FETCH0;
            r_a_vld    <= 1'b0;
            r_a_hit0   <= 1'b0;
            r_a_hit1   <= 1'b0;
            r_a_addr1  <= '0;
            r_a_vde    <= 1'b0;
            r_a_bg     <= '0;
            r_rom_addr <= '0;
        end else if (pix_ce) begin
            r_slot     <= FETCH0;
            r_a_vld    <= 1'b1;
            r_a_hit0   <= w_hit0;
            r_a_hit1   <= w_hit1;
            r_a_addr1  <= w_addr1;
            r_a_vde    <= vde;
            r_a_bg     <= {bg_red, bg_green, bg_blue};
            r_rom_addr <= w_addr0;
        end else begin
            r_a_vld <= 1'b0;
            case (r_slot)
                FETCH0: begin
                    r_slot     <= FETCH1;
                    r_rom_addr <= r_a_vld ? r_a_addr1 : '0;
                end
                FETCH1: begin
                    r_slot     <= FETCH0;
                    r_rom_addr <= '0;
                end
            endcase
        end
    end

    // Carry pixel attributes alongside the ROM latency; idx0 is captured as it returns
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_b_vld  <= 1'b0;
            r_b_hit0 <= 1'b0;
            r_b_hit1 <= 1'b0;
            r_b_vde  <= 1'b0;
            r_b_bg   <= '0;
            r_c_vld  <= 1'b0;
            r_c_hit0 <= 1'b0;
            r_c_hit1 <= 1'b0;
            r_c_vde  <= 1'b0;
            r_c_bg   <= '0;
            r_idx0   <= '0;
        end else begin
            r_b_vld  <= r_a_vld && !pix_ce;
            r_b_hit0 <= r_a_hit0;
            r_b_hit1 <= r_a_hit1;
            r_b_vde  <= r_a_vde;
            r_b_bg   <= r_a_bg;
            r_c_vld  <= r_b_vld;
            r_c_hit0 <= r_b_hit0;
            r_c_hit1 <= r_b_hit1;
            r_c_vde  <= r_b_vde;
            r_c_bg   <= r_b_bg;
            r_idx0   <= mem.rom_data;
        end
    end

    // Priority resolve: opaque tank 0, then opaque tank 1, else background (index 0)
    always_comb begin
        w_pick0     = r_c_hit0 && (r_idx0 != TRANSPARENT_IDX);
        w_pick1     = r_c_hit1 && (mem.rom_data != TRANSPARENT_IDX);
        w_pal_index = '0;
        if (r_c_vld) begin
            if (w_pick0) begin
                w_pal_index = r_idx0;
            end else if (w_pick1) begin
                w_pal_index = mem.rom_data;
            end
        end
    end

    // Output register: one strobe per resolved pixel, blanked outside active video
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_rgb       <= '0;
            r_pix_valid <= 1'b0;
        end else begin
            r_pix_valid <= r_c_vld && r_c_vde;
            if (r_c_vld) begin
                if (!r_c_vde) begin
                    r_rgb <= '0;
                end else if (w_pick0 || w_pick1) begin
                    r_rgb <= {mem.pal_red, mem.pal_green, mem.pal_blue};
                end else begin
                    r_rgb <= r_c_bg;
                end
            end
        end
    end

    assign mem.rom_addr  = r_rom_addr;
    assign mem.pal_index = w_pal_index;
    assign Red           = r_rgb.r;
    assign Green         = r_rgb.g;
    assign Blue          = r_rgb.b;
    assign pix_valid     = r_pix_valid;

endmodule

// File: tb/tb_tank_sprite_scheduler.sv
// Scoreboard bench for tank_sprite_scheduler with directed corner cases and random pixels.
module tb_tank_sprite_scheduler;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       pix_ce;
    logic [9:0] DrawX, DrawY;
    logic       vde;
    logic [3:0] bg_red, bg_green, bg_blue;
    logic [9:0] tank0_x, tank0_y, tank1_x, tank1_y;
    logic       tank0_en, tank1_en;
    logic [3:0] Red, Green, Blue;
    logic       pix_valid;

    int cyc = 0;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    tank_sprite_scheduler_if mem_if ();

    tank_sprite_scheduler dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .pix_ce    (pix_ce),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .vde       (vde),
        .bg_red    (bg_red),
        .bg_green  (bg_green),
        .bg_blue   (bg_blue),
        .tank0_x   (tank0_x),
        .tank0_y   (tank0_y),
        .tank1_x   (tank1_x),
        .tank1_y   (tank1_y),
        .tank0_en  (tank0_en),
        .tank1_en  (tank1_en),
        .mem       (mem_if),
        .Red       (Red),
        .Green     (Green),
        .Blue      (Blue),
        .pix_valid (pix_valid)
    );

    // Sprite ROM with one cycle of registered read latency, combinational palette
    logic [3:0] rom [0:2047];
    logic [3:0] pal_r [16];
    logic [3:0] pal_g [16];
    logic [3:0] pal_b [16];

    always @(posedge Clk) mem_if.rom_data <= rom[mem_if.rom_addr];
    assign mem_if.pal_red   = pal_r[mem_if.pal_index];
    assign mem_if.pal_green = pal_g[mem_if.pal_index];
    assign mem_if.pal_blue  = pal_b[mem_if.pal_index];

    typedef struct {
        int due;
        int a0;
        int a1;
        int pal;
        int rgb;
        bit vld;
        bit drop;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   last_issue = -10;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got 'h%0h, expected 'h%0h", name, cyc, act, exp);
        end
    endtask

    // Reference: box test and ROM lookup straight from pixel geometry
    task automatic tank_lookup(input int k, input int x, input int y, input int tx, input int ty,
                               input bit en, output bit hit, output int addr, output int idx);
        hit  = en && (x >= tx) && (x - tx < 32) && (y >= ty) && (y - ty < 32);
        addr = hit ? (k * 1024 + (y - ty) * 32 + (x - tx)) : 0;
        idx  = hit ? int'(rom[addr]) : 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Present one pixel for one pix_ce cycle, queue its expectation, then scramble the inputs
    task automatic issue(input int x, input int y, input bit v, input int bg,
                         input int t0x, input int t0y, input bit t0e,
                         input int t1x, input int t1y, input bit t1e);
        exp_t e;
        bit   h0, h1;
        int   ad0, ad1, i0, i1;
        DrawX    = 10'(x);   DrawY    = 10'(y);   vde = v;
        bg_red   = 4'(bg >> 8); bg_green = 4'(bg >> 4); bg_blue = 4'(bg);
        tank0_x  = 10'(t0x); tank0_y  = 10'(t0y); tank0_en = t0e;
        tank1_x  = 10'(t1x); tank1_y  = 10'(t1y); tank1_en = t1e;
        pix_ce   = 1'b1;
        tank_lookup(0, x, y, t0x, t0y, t0e, h0, ad0, i0);
        tank_lookup(1, x, y, t1x, t1y, t1e, h1, ad1, i1);
        if (last_issue == cyc - 1 && sb.size() > 0) sb[sb.size() - 1].drop = 1'b1;
        e.due  = cyc + 4;
        e.a0   = ad0;
        e.a1   = ad1;
        if (h0 && i0 != 0)      e.pal = i0;
        else if (h1 && i1 != 0) e.pal = i1;
        else                    e.pal = 0;
        if (!v)                 e.rgb = 0;
        else if (e.pal != 0)    e.rgb = int'({pal_r[e.pal], pal_g[e.pal], pal_b[e.pal]});
        else                    e.rgb = bg & 12'hFFF;
        e.vld  = v;
        e.drop = 1'b0;
        sb.push_back(e);
        last_issue = cyc;
        @(posedge Clk);
        #1;
        pix_ce   = 1'b0;
        DrawX    = 10'($urandom); DrawY   = 10'($urandom); vde = 1'($urandom);
        tank0_x  = 10'($urandom); tank1_x = 10'($urandom);
        tank0_en = 1'($urandom);  bg_red  = 4'($urandom);
    endtask

    task automatic do_reset();
        Reset_n    = 1'b0;
        pix_ce     = 1'b0;
        sb.delete();
        last_issue = -10;
        @(posedge Clk);
        @(negedge Clk);
        check("rst_rom_addr",  int'(mem_if.rom_addr), 0);
        check("rst_pal_index", int'(mem_if.pal_index), 0);
        check("rst_red",       int'(Red), 0);
        check("rst_green",     int'(Green), 0);
        check("rst_blue",      int'(Blue), 0);
        check("rst_pix_valid", int'(pix_valid), 0);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
    endtask

    function automatic int near(input int c);
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 1023));
        return (c - int'($urandom_range(0, 40))) & 1023;
    endfunction

    // Monitor: compares whatever the DUT presents against the queued expectations for this cycle
    always @(negedge Clk) begin
        bit out_due;
        if (Reset_n) begin
            out_due = 1'b0;
            foreach (sb[i]) begin
                if (sb[i].due - 3 == cyc)
                    check("rom_addr_tank0", int'(mem_if.rom_addr), sb[i].a0);
                if (!sb[i].drop && sb[i].due - 2 == cyc)
                    check("rom_addr_tank1", int'(mem_if.rom_addr), sb[i].a1);
                if (!sb[i].drop && sb[i].due - 1 == cyc)
                    check("pal_index", int'(mem_if.pal_index), sb[i].pal);
                if (sb[i].due == cyc) begin
                    out_due = 1'b1;
                    if (sb[i].drop) begin
                        check("dropped_pix_valid", int'(pix_valid), 0);
                    end else begin
                        check("pix_valid", int'(pix_valid), int'(sb[i].vld));
                        check("rgb", int'({Red, Green, Blue}), sb[i].rgb);
                    end
                end
            end
            if (!out_due && pix_valid)
                check("unexpected_pix_valid", int'(pix_valid), 0);
            while (sb.size() > 0 && sb[0].due <= cyc) void'(sb.pop_front());
        end
    end

    initial begin
        int x, y;
        pix_ce = 1'b0; DrawX = '0; DrawY = '0; vde = 1'b0;
        bg_red = '0; bg_green = '0; bg_blue = '0;
        tank0_x = '0; tank0_y = '0; tank1_x = '0; tank1_y = '0;
        tank0_en = 1'b0; tank1_en = 1'b0;

        for (int i = 0; i < 2048; i++)
            rom[i] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        for (int i = 0; i < 16; i++) begin
            pal_r[i] = 4'($urandom); pal_g[i] = 4'($urandom); pal_b[i] = 4'($urandom);
        end
        rom[0]     = 4'hA;
        rom[11'h14A] = 4'h3;
        rom[490]   = 4'h0;
        rom[1189]  = 4'h7;
        pal_r[3] = 4'hE; pal_g[3] = 4'h7; pal_b[3] = 4'h2;
        pal_r[7] = 4'h9; pal_g[7] = 4'h3; pal_b[7] = 4'h1;
        pal_r[5] = 4'h1; pal_g[5] = 4'h1; pal_b[5] = 4'h1;

        @(posedge Clk);
        #1;
        do_reset();

        // Single tank hit
        issue(110, 60, 1'b1, 12'h456, 100, 50, 1'b1, 900, 900, 1'b0); idle(1);
        // Overlap: transparent tank 0 reveals tank 1, then opaque tank 0 wins
        issue(200, 200, 1'b1, 12'h0F0, 190, 185, 1'b1, 195, 195, 1'b1); idle(5);
        rom[490] = 4'h5;
        issue(200, 200, 1'b1, 12'h0F0, 190, 185, 1'b1, 195, 195, 1'b1); idle(1);
        // Right-edge hit, then next line start must not wrap
        issue(639, 300, 1'b1, 12'h123, 5, 5, 1'b0, 620, 290, 1'b1); idle(1);
        issue(0,   301, 1'b1, 12'h321, 5, 5, 1'b0, 620, 290, 1'b1); idle(1);
        // Blanking with a hit, disabled tank inside its box
        issue(110, 60, 1'b0, 12'hABC, 100, 50, 1'b1, 100, 50, 1'b1); idle(1);
        issue(110, 60, 1'b1, 12'hBEE, 100, 50, 1'b0, 100, 50, 1'b0); idle(1);
        // Back-to-back pix_ce drops the first pixel
        issue(110, 60, 1'b1, 12'h111, 100, 50, 1'b1, 0, 0, 1'b0);
        issue(205, 210, 1'b1, 12'h222, 190, 185, 1'b1, 195, 195, 1'b1); idle(1);
        // Reset with pixels in flight
        issue(111, 61, 1'b1, 12'h333, 100, 50, 1'b1, 100, 50, 1'b1);
        issue(112, 62, 1'b1, 12'h444, 100, 50, 1'b1, 100, 50, 1'b1);
        do_reset();
        issue(110, 60, 1'b1, 12'h555, 100, 50, 1'b1, 0, 0, 1'b0); idle(1);

        // Random pixels with tanks placed near the beam
        for (int n = 0; n < 600; n++) begin
            x = int'($urandom_range(0, 1023));
            y = int'($urandom_range(0, 1023));
            issue(x, y, ($urandom_range(0, 6) != 0), int'($urandom_range(0, 4095)),
                  near(x), near(y), ($urandom_range(0, 4) != 0),
                  near(x), near(y), ($urandom_range(0, 4) != 0));
            if (n == 350) do_reset();
            else if ($urandom_range(0, 15) != 0) idle(int'($urandom_range(1, 3)));
        end

        idle(10);
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
